// File: rtl/bypass_control_unit_pkg.sv
// Shared types and constants for the bypass/hazard controller: RV32I opcodes,
// bypass select encodings, the per-stage scoreboard record and the select resolver.
package bypass_control_unit_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;

    localparam logic [2:0] BypRf = 3'b000;
    localparam logic [2:0] BypE  = 3'b001;
    localparam logic [2:0] BypM1 = 3'b010;
    localparam logic [2:0] BypM2 = 3'b011;
    localparam logic [2:0] BypWb = 3'b100;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } stage_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       load_hazard;
    } byp_t;

    function automatic logic stage_match(input stage_t s, input logic [4:0] rs);
        return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

    // Youngest producer wins; a load still short of WB cannot supply its data.
    function automatic byp_t resolve_bypass(input stage_t e, input stage_t m1, input stage_t m2,
                                            input stage_t wb, input logic [4:0] rs,
                                            input logic en);
        byp_t r;
        r.sel         = BypRf;
        r.load_hazard = 1'b0;
        if (en) begin
            if (stage_match(e, rs)) begin
                r.sel         = BypE;
                r.load_hazard = e.is_load;
            end else if (stage_match(m1, rs)) begin
                r.sel         = BypM1;
                r.load_hazard = m1.is_load;
            end else if (stage_match(m2, rs)) begin
                r.sel         = BypM2;
                r.load_hazard = m2.is_load;
            end else if (stage_match(wb, rs)) begin
                r.sel = BypWb;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bypass_opcode_classify.sv
// Combinational RV32I opcode classifier: which source operands are read,
// whether a register is written, and whether the instruction is a load.
module bypass_opcode_classify
    import bypass_control_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       regwrite_o,
    output logic       is_load_o
);

    always_comb begin
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        regwrite_o = 1'b0;
        is_load_o  = 1'b0;
        case (opcode_i)
            OpR: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                regwrite_o = 1'b1;
            end
            OpIAlu, OpJalr: begin
                uses_rs1_o = 1'b1;
                regwrite_o = 1'b1;
            end
            OpLoad: begin
                uses_rs1_o = 1'b1;
                regwrite_o = 1'b1;
                is_load_o  = 1'b1;
            end
            OpStore, OpBranch: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            OpLui, OpAuipc, OpJal: begin
                regwrite_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bypass_control_unit.sv
// Forwarding/load-use hazard controller for the 7-stage pipeline with a shadow
// scoreboard of E..WB. Define HAZARD_COUNTERS_EN to build the stall/bypass counters.
module bypass_control_unit
    import bypass_control_unit_pkg::*;
#(
    parameter int unsigned CORE          = 0,
    parameter int unsigned REG_SEL_BITS  = 5,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     decode_valid_i,
    input  logic [6:0]               opcode_i,
    input  logic [REG_SEL_BITS-1:0]  rs1_i,
    input  logic [REG_SEL_BITS-1:0]  rs2_i,
    input  logic [REG_SEL_BITS-1:0]  rd_i,
    input  logic                     flush_i,
    output logic [2:0]               rs1_data_bypass_o,
    output logic [2:0]               rs2_data_bypass_o,
    output logic                     stall_o,
    output logic [COUNTER_WIDTH-1:0] stall_count_o,
    output logic [COUNTER_WIDTH-1:0] bypass_count_o,
    input  logic                     report_i
);

    stage_t e_q, m1_q, m2_q, wb_q;
    stage_t e_d;

    logic uses_rs1, uses_rs2, regwrite, is_load;
    byp_t byp1, byp2;
    logic hazard;

    bypass_opcode_classify u_classify (
        .opcode_i   (opcode_i),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .regwrite_o (regwrite),
        .is_load_o  (is_load)
    );

    always_comb begin
        byp1   = resolve_bypass(e_q, m1_q, m2_q, wb_q, rs1_i, decode_valid_i & uses_rs1);
        byp2   = resolve_bypass(e_q, m1_q, m2_q, wb_q, rs2_i, decode_valid_i & uses_rs2);
        hazard = byp1.load_hazard | byp2.load_hazard;

        // A resolved control transfer kills D, so it never waits on a load.
        stall_o           = hazard & ~flush_i;
        rs1_data_bypass_o = stall_o ? BypRf : byp1.sel;
        rs2_data_bypass_o = stall_o ? BypRf : byp2.sel;

        e_d = '0;
        if (!(stall_o || flush_i || !decode_valid_i)) begin
            e_d.valid    = 1'b1;
            e_d.rd       = rd_i;
            e_d.regwrite = regwrite;
            e_d.is_load  = is_load;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            e_q  <= '0;
            m1_q <= '0;
            m2_q <= '0;
            wb_q <= '0;
        end else begin
            e_q  <= e_d;
            m1_q <= e_q;
            m2_q <= m1_q;
            wb_q <= m2_q;
        end
    end

`ifdef HAZARD_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNTER_WIDTH-1:0] byp_cnt_q, byp_cnt_d;
    logic                     any_bypass;

    always_comb begin
        any_bypass  = (rs1_data_bypass_o != BypRf) || (rs2_data_bypass_o != BypRf);
        stall_cnt_d = stall_cnt_q;
        byp_cnt_d   = byp_cnt_q;
        if (stall_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + COUNTER_WIDTH'(1);
        end
        if (!stall_o && any_bypass && !(&byp_cnt_q)) begin
            byp_cnt_d = byp_cnt_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            byp_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            byp_cnt_q   <= byp_cnt_d;
        end
    end

    assign stall_count_o  = stall_cnt_q;
    assign bypass_count_o = byp_cnt_q;
`else
    assign stall_count_o  = '0;
    assign bypass_count_o = '0;
`endif

    // The report hook is a simulation-only debug aid; nothing to print in hardware.
    logic unused_report;
    assign unused_report = report_i ^ (CORE != 0);

endmodule

// File: tb/tb_bypass_control_unit.sv
// Scoreboard bench for bypass_control_unit: directed vectors push expected
// selects/stall/counters into a queue that a negedge monitor pops and checks.
module tb_bypass_control_unit;

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] L = 7'b0000011;
    localparam logic [6:0] S = 7'b0100011;
    localparam logic [6:0] U = 7'b0110111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        decode_valid = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic        flush = 1'b0;
    logic        report = 1'b0;
    logic [2:0]  rs1_sel, rs2_sel;
    logic        stall;
    logic [31:0] stall_count, bypass_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        chk;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        st;
        logic [31:0] sc;
        logic [31:0] bc;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_sc = 0;
    logic [31:0] exp_bc = 0;

    bypass_control_unit #(
        .CORE          (0),
        .REG_SEL_BITS  (5),
        .COUNTER_WIDTH (32)
    ) dut (
        .clock_i           (clock),
        .reset_i           (reset),
        .decode_valid_i    (decode_valid),
        .opcode_i          (opcode),
        .rs1_i             (rs1),
        .rs2_i             (rs2),
        .rd_i              (rd),
        .flush_i           (flush),
        .rs1_data_bypass_o (rs1_sel),
        .rs2_data_bypass_o (rs2_sel),
        .stall_o           (stall),
        .stall_count_o     (stall_count),
        .bypass_count_o    (bypass_count),
        .report_i          (report)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input string fld, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    // Drive one D-stage cycle and enqueue what the outputs must show during it.
    task automatic drive(input logic dv, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d, input logic fl,
                         input logic rst, input logic ck, input logic [2:0] e1,
                         input logic [2:0] e2, input logic es, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        decode_valid = dv;
        opcode       = op;
        rs1          = r1;
        rs2          = r2;
        rd           = d;
        flush        = fl;
        reset        = rst;
        e.chk  = ck;
        e.s1   = e1;
        e.s2   = e2;
        e.st   = es;
        e.name = nm;
`ifdef HAZARD_COUNTERS_EN
        e.sc = exp_sc;
        e.bc = exp_bc;
`else
        e.sc = 0;
        e.bc = 0;
`endif
        sbq.push_back(e);
        if (rst) begin
            exp_sc = 0;
            exp_bc = 0;
        end else begin
            if (es) exp_sc = exp_sc + 1;
            if (!es && (e1 != 3'd0 || e2 != 3'd0)) exp_bc = exp_bc + 1;
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) drive(0, R, 0, 0, 0, 0, 0, 1, 0, 0, 0, "drain");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    check(e.name, "rs1_sel", 32'(rs1_sel), 32'(e.s1));
                    check(e.name, "rs2_sel", 32'(rs2_sel), 32'(e.s2));
                    check(e.name, "stall", 32'(stall), 32'(e.st));
                    check(e.name, "stall_count", stall_count, e.sc);
                    check(e.name, "bypass_count", bypass_count, e.bc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        //    dv op r1 r2 rd fl rst ck e1 e2 st
        drive(0, R, 0, 0, 0, 0, 1, 0, 0, 0, 0, "reset");
        drive(0, R, 0, 0, 0, 0, 1, 0, 0, 0, 0, "reset");
        drive(0, R, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_state");

        drive(1, R, 1, 2, 5, 0, 0, 1, 0, 0, 0, "c1_prod");
        drive(1, R, 5, 3, 7, 0, 0, 1, 1, 0, 0, "c1_use_e");
        drain(4);

        drive(1, I, 1, 0, 5, 0, 0, 1, 0, 0, 0, "c2_addi5");
        drive(1, R, 0, 0, 9, 0, 0, 1, 0, 0, 0, "c2_add9");
        drive(1, R, 0, 0, 5, 0, 0, 1, 0, 0, 0, "c2_add5");
        drive(1, R, 3, 5, 10, 0, 0, 1, 0, 1, 0, "c2_e_over_m2");
        drive(1, R, 5, 9, 11, 0, 0, 1, 2, 3, 0, "c2_m1_m2");
        drive(1, R, 5, 9, 0, 0, 0, 1, 3, 4, 0, "c2_m2_wb");
        drain(4);

        drive(1, L, 1, 0, 6, 0, 0, 1, 0, 0, 0, "c3_lw");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 0, 1, "c3_stall1");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 0, 1, "c3_stall2");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 0, 1, "c3_stall3");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 4, 0, "c3_wb_go");
        drain(4);

        drive(1, I, 1, 0, 0, 0, 0, 1, 0, 0, 0, "c4_addi_x0");
        drive(1, R, 0, 0, 3, 0, 0, 1, 0, 0, 0, "c4_use_x0");
        drive(1, I, 0, 0, 5, 0, 0, 1, 0, 0, 0, "c4_addi5");
        drive(1, U, 5, 5, 12, 0, 0, 1, 0, 0, 0, "c4_lui_nouse");
        drive(1, S, 12, 5, 0, 0, 0, 1, 1, 2, 0, "c4_store");
        drain(4);

        drive(1, L, 1, 0, 6, 0, 0, 1, 0, 0, 0, "c5_lw");
        drive(1, R, 2, 6, 9, 1, 0, 1, 0, 1, 0, "c5_flush");
        drive(1, R, 9, 0, 0, 0, 0, 1, 0, 0, 0, "c5_e_bubble");
        drain(4);

        drive(1, L, 1, 0, 6, 0, 0, 1, 0, 0, 0, "c6_lw");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 0, 1, "c6_stall1");
        drive(1, R, 2, 6, 8, 0, 1, 1, 0, 0, 1, "c6_stall2_rst");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 0, 0, "c6_after_rst");
        drive(1, R, 2, 6, 8, 0, 0, 1, 0, 0, 0, "c6_after_rst2");
        drain(2);

        @(posedge clock);
        @(posedge clock);
        check("sb", "pending", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
